// File: rtl/req_sched_pkg.sv
// -----------------------------------------------------------------------------
// req_sched_pkg
// Shared types and defaults for the round-robin request scheduler family.
//   state_t  : scheduler FSM states
//   DEF_*    : default parameter values
//   rr_pick  : behavioural round-robin pick over up to MAX_CLIENTS requesters,
//              returning {valid, index}; searches from ptr+1 with wrap-around.
// -----------------------------------------------------------------------------
package req_sched_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      GRANT   = 2'd2,
      RELEASE = 2'd3
   } state_t;

   localparam int DEF_N_CLIENTS   = 4;
   localparam int DEF_HOLD_CYCLES = 2;
   localparam int DEF_TIMEOUT     = 8;
   localparam int MAX_CLIENTS     = 16;

   typedef struct packed {
      logic       valid;
      logic [3:0] index;
   } rr_pick_t;

   // Only the low n bits of req_vec are considered; n must be 2..MAX_CLIENTS.
   function automatic rr_pick_t rr_pick(input logic [MAX_CLIENTS-1:0] req_vec,
                                        input logic [3:0]             ptr,
                                        input int                     n);
      rr_pick_t res;
      int       idx;
      res = '0;
      for (int i = 1; i <= MAX_CLIENTS; i++) begin
         idx = (int'(ptr) + i) % n;
         if (i <= n && !res.valid && req_vec[idx[3:0]]) begin
            res.valid = 1'b1;
            res.index = idx[3:0];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/req_rr_scheduler_rr_pick_comb.sv
// -----------------------------------------------------------------------------
// rr_pick_comb
// Combinational round-robin selector: rotates the request vector so the
// client after ptr sits at bit 0, priority-encodes the lowest set bit, then
// un-rotates the result back to a client index.
// Ports:
//   req_vec : N request bits
//   ptr     : last winner; search starts at ptr+1 (mod N)
//   valid   : at least one request is set
//   index   : chosen client (meaningful only when valid)
// -----------------------------------------------------------------------------
module rr_pick_comb
   import req_sched_pkg::*;
#(
   parameter int N = DEF_N_CLIENTS,
   parameter int W = $clog2(N)
)(
   input  logic [N-1:0] req_vec,
   input  logic [W-1:0] ptr,
   output logic         valid,
   output logic [W-1:0] index
);

   logic [W-1:0]   start;
   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic [W-1:0]   offset;
   logic [W:0]     sum;

   // NOTE: every signal driven here gets a value before any conditional
   // update, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      start  = (ptr == W'(N-1)) ? '0 : ptr + 1'b1;
      // Doubling the vector turns the rotate into a plain right shift.
      dbl    = {req_vec, req_vec} >> start;
      rot    = dbl[N-1:0];
      valid  = |rot;
      offset = '0;
      for (int i = N-1; i >= 0; i--) begin
         if (rot[i]) offset = W'(i);
      end
      sum = {1'b0, start} + {1'b0, offset};
      if (sum >= (W+1)'(N)) index = W'(sum - (W+1)'(N));
      else                  index = sum[W-1:0];
   end

endmodule

// File: rtl/req_rr_scheduler.sv
// -----------------------------------------------------------------------------
// req_rr_scheduler
// Round-robin arbiter in front of a request/grant stage. A winning client's
// request is forwarded as `req`; when the stage echoes `gnt`, the client sees
// a one-hot grant for HOLD_CYCLES cycles. Missing or stuck `gnt` answers are
// reported with a one-cycle timeout_err pulse.
// Ports:
//   clk         : clock, rising edge
//   reset       : asynchronous, active-high
//   client_req  : per-client request levels
//   client_gnt  : one-hot grant to the winner (registered)
//   client_id   : current / last winner index (registered)
//   req         : request to the grant stage (registered)
//   gnt         : grant from the grant stage, nominally req delayed one cycle
//   busy        : scheduler not idle (registered)
//   timeout_err : one-cycle pulse on a grant-stage timeout (registered)
// -----------------------------------------------------------------------------
module req_rr_scheduler
   import req_sched_pkg::*;
#(
   parameter int N_CLIENTS   = DEF_N_CLIENTS,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int TIMEOUT     = DEF_TIMEOUT
)(
   input  logic                         clk,
   input  logic                         reset,
   input  logic [N_CLIENTS-1:0]         client_req,
   output logic [N_CLIENTS-1:0]         client_gnt,
   output logic [$clog2(N_CLIENTS)-1:0] client_id,
   output logic                         req,
   input  logic                         gnt,
   output logic                         busy,
   output logic                         timeout_err
);

   localparam int IDW     = $clog2(N_CLIENTS);
   // The counter also times the hold window, so size it for the larger need.
   localparam int CNT_MAX = (TIMEOUT > HOLD_CYCLES) ? TIMEOUT : HOLD_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0]  TO_LAST   = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0]  HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0]  CNT_SAT   = CW'(CNT_MAX);
   localparam logic [IDW-1:0] PTR_INIT  = IDW'(N_CLIENTS - 1);

   state_t               state, state_nx;
   logic [CW-1:0]        cnt, cnt_nx, cnt_inc;
   logic [IDW-1:0]       ptr, ptr_nx, client_id_nx;
   logic [N_CLIENTS-1:0] client_gnt_nx;
   logic                 req_nx, busy_nx, timeout_err_nx;
   logic                 granted, granted_nx;
   logic                 pick_valid;
   logic [IDW-1:0]       pick_idx;
   logic                 win_req;

   rr_pick_comb #(
      .N (N_CLIENTS),
      .W (IDW)
   ) u_pick (
      .req_vec (client_req),
      .ptr     (ptr),
      .valid   (pick_valid),
      .index   (pick_idx)
   );

   assign win_req = client_req[client_id];
   assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;

   always_comb begin
      state_nx       = state;
      cnt_nx         = cnt;
      ptr_nx         = ptr;
      client_id_nx   = client_id;
      client_gnt_nx  = client_gnt;
      req_nx         = req;
      granted_nx     = granted;
      timeout_err_nx = 1'b0;

      unique case (state)
         IDLE: begin
            if (pick_valid) begin
               state_nx     = REQ;
               req_nx       = 1'b1;
               client_id_nx = pick_idx;
               cnt_nx       = '0;
               granted_nx   = 1'b0;
            end
         end

         REQ: begin
            // A withdrawn request wins over a simultaneous gnt.
            if (!win_req) begin
               state_nx = RELEASE;
               req_nx   = 1'b0;
               cnt_nx   = '0;
            end else if (gnt) begin
               state_nx      = GRANT;
               client_gnt_nx = N_CLIENTS'(1) << client_id;
               cnt_nx        = '0;
            end else if (cnt == TO_LAST) begin
               state_nx       = RELEASE;
               req_nx         = 1'b0;
               cnt_nx         = '0;
               timeout_err_nx = 1'b1;
            end else begin
               cnt_nx = cnt_inc;
            end
         end

         GRANT: begin
            if (!win_req || cnt == HOLD_LAST) begin
               state_nx      = RELEASE;
               client_gnt_nx = '0;
               req_nx        = 1'b0;
               cnt_nx        = '0;
               granted_nx    = 1'b1;
            end else begin
               cnt_nx = cnt_inc;
            end
         end

         RELEASE: begin
            if (!gnt) begin
               state_nx = IDLE;
               // Only a served grant moves the pointer; otherwise retry.
               if (granted) ptr_nx = client_id;
            end else if (cnt == TO_LAST) begin
               // Stuck gnt: advance anyway so one client cannot livelock.
               state_nx       = IDLE;
               ptr_nx         = client_id;
               timeout_err_nx = 1'b1;
            end else begin
               cnt_nx = cnt_inc;
            end
         end

         default: begin
            state_nx      = IDLE;
            req_nx        = 1'b0;
            client_gnt_nx = '0;
            cnt_nx        = '0;
         end
      endcase

      busy_nx = (state_nx != IDLE);
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values computed above, independent of block order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         ptr         <= PTR_INIT;
         client_id   <= '0;
         client_gnt  <= '0;
         req         <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         granted     <= 1'b0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         ptr         <= ptr_nx;
         client_id   <= client_id_nx;
         client_gnt  <= client_gnt_nx;
         req         <= req_nx;
         busy        <= busy_nx;
         timeout_err <= timeout_err_nx;
         granted     <= granted_nx;
      end
   end

endmodule

// File: tb/tb_req_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_req_rr_scheduler
// Directed bench for req_rr_scheduler (N_CLIENTS=4, HOLD_CYCLES=2, TIMEOUT=8).
// A small grant-stage model drives gnt as an echo of req, tied low, or
// sticky-high. Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_req_rr_scheduler;

   typedef enum logic [1:0] {GS_ECHO, GS_TIE0, GS_STICKY} gs_mode_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] client_req;
   logic [3:0] client_gnt;
   logic [1:0] client_id;
   logic       req;
   logic       gnt = 1'b0;
   logic       busy;
   logic       timeout_err;

   gs_mode_t   mode = GS_ECHO;
   int         total = 0;
   int         bad = 0;
   int         to_pulses = 0;
   int         pulses0;
   logic [1:0] exp_id;
   logic [3:0] exp_oh;

   req_rr_scheduler #(
      .N_CLIENTS   (4),
      .HOLD_CYCLES (2),
      .TIMEOUT     (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .client_req  (client_req),
      .client_gnt  (client_gnt),
      .client_id   (client_id),
      .req         (req),
      .gnt         (gnt),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   // Grant-stage model.
   always @(posedge clk) begin
      case (mode)
         GS_ECHO: gnt <= req;
         GS_TIE0: gnt <= 1'b0;
         default: gnt <= req | gnt;
      endcase
   end

   always @(negedge clk) begin
      if (timeout_err === 1'b1) to_pulses <= to_pulses + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      client_req = 4'b0000;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      client_req = 4'b0000;
      tick();
      tick();
      check("rst_req", req, 0);
      check("rst_busy", busy, 0);
      check("rst_client_gnt", client_gnt, 0);
      check("rst_client_id", client_id, 0);
      check("rst_timeout", timeout_err, 0);

      // 1: single client, nominal latency, pointer lands on client 1
      reset      = 1'b0;
      client_req = 4'b0010;
      tick();
      check("t1_req_e0", req, 1);
      check("t1_busy_e0", busy, 1);
      check("t1_id_e0", client_id, 1);
      check("t1_cgnt_e0", client_gnt, 0);
      tick();
      check("t1_cgnt_e1", client_gnt, 0);
      check("t1_req_e1", req, 1);
      tick();
      check("t1_cgnt_e2", client_gnt, 4'b0010);
      tick();
      check("t1_cgnt_e3", client_gnt, 4'b0010);
      check("t1_req_e3", req, 1);
      tick();
      check("t1_cgnt_e4", client_gnt, 0);
      check("t1_req_e4", req, 0);
      check("t1_busy_e4", busy, 1);
      client_req = 4'b0000;
      tick();
      check("t1_busy_e5", busy, 1);
      tick();
      check("t1_busy_e6", busy, 0);
      client_req = 4'b0101;
      tick();
      check("t1_ptr_next_id", client_id, 2);
      check("t1_ptr_next_req", req, 1);

      // 2: all clients requesting, five grants in rotation
      mode = GS_ECHO;
      do_reset();
      client_req = 4'b1111;
      pulses0    = to_pulses;
      for (int k = 0; k < 5; k++) begin
         exp_id = 2'(k % 4);
         exp_oh = 4'b0001 << exp_id;
         tick();
         check($sformatf("t2_id_%0d", k), client_id, exp_id);
         check($sformatf("t2_req_%0d", k), req, 1);
         tick();
         tick();
         check($sformatf("t2_cgnt_a_%0d", k), client_gnt, exp_oh);
         tick();
         check($sformatf("t2_cgnt_b_%0d", k), client_gnt, exp_oh);
         tick();
         check($sformatf("t2_cgnt_off_%0d", k), client_gnt, 0);
         tick();
         tick();
         check($sformatf("t2_idle_%0d", k), busy, 0);
      end
      check("t2_no_timeout", to_pulses - pulses0, 0);

      // 3: gnt never arrives, REQ timeout, same client retried
      mode = GS_TIE0;
      do_reset();
      client_req = 4'b0100;
      tick();
      check("t3_req_e0", req, 1);
      check("t3_id_e0", client_id, 2);
      for (int i = 1; i < 8; i++) begin
         tick();
         check($sformatf("t3_req_e%0d", i), req, 1);
         check($sformatf("t3_cgnt_e%0d", i), client_gnt, 0);
         check($sformatf("t3_to_e%0d", i), timeout_err, 0);
      end
      tick();
      check("t3_req_e8", req, 0);
      check("t3_to_e8", timeout_err, 1);
      check("t3_cgnt_e8", client_gnt, 0);
      tick();
      check("t3_to_e9", timeout_err, 0);
      check("t3_busy_e9", busy, 0);
      tick();
      check("t3_retry_req", req, 1);
      check("t3_retry_id", client_id, 2);

      // 4: withdraw in REQ; pointer stays at previous winner (client 1)
      mode = GS_ECHO;
      do_reset();
      client_req = 4'b0010;
      tick();
      check("t4_first_id", client_id, 1);
      tick();
      tick();
      tick();
      tick();
      client_req = 4'b0000;
      tick();
      tick();
      check("t4_first_idle", busy, 0);
      client_req = 4'b1000;
      tick();
      check("t4_req_up", req, 1);
      check("t4_id", client_id, 3);
      client_req = 4'b0000;
      tick();
      check("t4_wd_req", req, 0);
      check("t4_wd_busy", busy, 1);
      check("t4_wd_cgnt", client_gnt, 0);
      check("t4_wd_to", timeout_err, 0);
      tick();
      check("t4_rel_cgnt", client_gnt, 0);
      check("t4_rel_to", timeout_err, 0);
      tick();
      check("t4_idle", busy, 0);
      client_req = 4'b1010;
      tick();
      check("t4_ptr_kept_id", client_id, 3);

      // 5: asynchronous reset in the middle of a grant
      mode = GS_ECHO;
      do_reset();
      client_req = 4'b1000;
      tick();
      tick();
      tick();
      check("t5_cgnt_before", client_gnt, 4'b1000);
      #2;
      reset = 1'b1;
      #1;
      check("t5_async_cgnt", client_gnt, 0);
      check("t5_async_req", req, 0);
      check("t5_async_busy", busy, 0);
      check("t5_async_id", client_id, 0);
      client_req = 4'b1111;
      tick();
      tick();
      reset = 1'b0;
      tick();
      check("t5_after_id", client_id, 0);
      check("t5_after_req", req, 1);

      // 6: gnt stuck high after the grant, RELEASE timeout
      mode = GS_STICKY;
      do_reset();
      client_req = 4'b0001;
      tick();
      check("t6_id", client_id, 0);
      tick();
      tick();
      check("t6_cgnt", client_gnt, 4'b0001);
      tick();
      tick();
      check("t6_rel_req", req, 0);
      check("t6_rel_cgnt", client_gnt, 0);
      check("t6_rel_busy", busy, 1);
      client_req = 4'b0000;
      repeat (7) tick();
      check("t6_wait_busy", busy, 1);
      check("t6_wait_to", timeout_err, 0);
      tick();
      check("t6_to_pulse", timeout_err, 1);
      check("t6_to_busy", busy, 0);
      check("t6_to_req", req, 0);
      tick();
      check("t6_to_clear", timeout_err, 0);
      check("t6_idle_busy", busy, 0);
      tick();
      check("t6_idle_ignores_gnt", req, 0);

      mode = GS_ECHO;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
